pin_entry_ctrl: RTL and testbench

Button-driven front end that produces the 16-bit BCD `Pin` word and the exit strobe consumed by the parking controller's exit/billing path. It debounces four raw push-buttons and lets the user dial four decimal digits with a cursor. On enter it presents the completed word plus a one-cycle valid pulse. It sits between the board buttons and the parking controller, replacing direct switch wiring of `Pin`.

---
 rtl/pin_entry_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/pin_entry_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pin_entry_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_entry_pkg.sv
// pin_entry_pkg: shared constants, FSM state type and digit helper for pin_entry_ctrl.
//   NUM_DIGITS   - number of BCD digits in the entry word
//   DIGIT_MAX    - largest value a digit may hold
//   BTN_*        - indices of the buttons in the internal button vectors
//   pin_state_e  - entry FSM states
package pin_entry_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  DIGIT_MAX  = 4'd9;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_NEXT  = 1;
    localparam int unsigned BTN_ENTER = 2;
    localparam int unsigned BTN_CLEAR = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEdit = 2'd1,
        StDone = 2'd2
    } pin_state_e;

    // BCD increment, 9 wraps to 0.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: debounces one raw push-button.
//   clk     - system clock
//   clr_n   - asynchronous active-low reset
//   btn_i   - raw button level
//   level_o - debounced level
//   press_o - one-cycle pulse on the rising edge of the debounced level
// The level follows the raw input only after the raw input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; any return to the current level restarts the count.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (btn_i != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = btn_i;
                press_d = btn_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: four-button BCD PIN entry front end.
//   clk, clr_n                       - clock, asynchronous active-low reset
//   btn_up/btn_next/btn_enter/btn_clear - raw push-buttons
//   pin       - four registered BCD digits, digit 3 in [15:12]
//   pin_valid - one-cycle pulse when an entry is committed
//   cursor    - index of the digit being edited
//   editing   - high while in the edit state
//   timeout   - one-cycle pulse when an edit is abandoned for inactivity
// Optional feature: define PIN_ENTRY_TIMEOUT_EN to build the inactivity timeout.
module pin_entry_ctrl
    import pin_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        btn_up,
    input  logic        btn_next,
    input  logic        btn_enter,
    input  logic        btn_clear,
    output logic [15:0] pin,
    output logic        pin_valid,
    output logic [1:0]  cursor,
    output logic        editing,
    output logic        timeout
);

    logic [3:0] raw_btn, btn_level, btn_press;

    assign raw_btn[BTN_UP]    = btn_up;
    assign raw_btn[BTN_NEXT]  = btn_next;
    assign raw_btn[BTN_ENTER] = btn_enter;
    assign raw_btn[BTN_CLEAR] = btn_clear;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .clr_n  (clr_n),
            .btn_i  (raw_btn[i]),
            .level_o(btn_level[i]),
            .press_o(btn_press[i])
        );
    end

    // Debounced levels are not needed here; only the press pulses drive the FSM.
    logic unused_btn_level;
    assign unused_btn_level = ^btn_level;

    // Single winning press: clear > enter > next > up.
    logic p_clear, p_enter, p_next, p_up;
    assign p_clear = btn_press[BTN_CLEAR];
    assign p_enter = btn_press[BTN_ENTER] & ~p_clear;
    assign p_next  = btn_press[BTN_NEXT] & ~p_clear & ~btn_press[BTN_ENTER];
    assign p_up    = btn_press[BTN_UP] & ~(|btn_press[BTN_CLEAR:BTN_NEXT]);

    pin_state_e                       state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]       dig_q, dig_d;
    logic [1:0]                       cursor_q, cursor_d;
    logic                             valid_q, valid_d;
    logic                             timeout_q, timeout_d;
    logic                             to_expire;

`ifdef PIN_ENTRY_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    // Any press restarts the idle count, so a same-cycle press always beats expiry.
    always_comb begin
        to_cnt_d  = '0;
        to_expire = 1'b0;
        if (!(|btn_press) && (state_q == StEdit)) begin
            if (to_cnt_q == ToMax) begin
                to_expire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign to_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        cursor_d  = cursor_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (p_up) begin
                    dig_d[cursor_q] = digit_inc(dig_q[cursor_q]);
                    state_d         = StEdit;
                end else if (p_next) begin
                    cursor_d = cursor_q - 2'd1;
                    state_d  = StEdit;
                end
            end
            StEdit: begin
                if (p_clear) begin
                    dig_d    = '0;
                    cursor_d = 2'd3;
                    state_d  = StIdle;
                end else if (p_enter) begin
                    valid_d = 1'b1;
                    state_d = StDone;
                end else if (p_next) begin
                    cursor_d = cursor_q - 2'd1;
                end else if (p_up) begin
                    dig_d[cursor_q] = digit_inc(dig_q[cursor_q]);
                end
            end
            StDone: begin
                if (p_clear) begin
                    dig_d    = '0;
                    cursor_d = 2'd3;
                    state_d  = StIdle;
                end else if (p_enter) begin
                    valid_d = 1'b1;
                end else if (p_next || p_up) begin
                    // The press only reopens editing; it is not applied to the digits.
                    dig_d    = '0;
                    cursor_d = 2'd3;
                    state_d  = StEdit;
                end
            end
            default: state_d = StIdle;
        endcase
        if (to_expire) begin
            dig_d     = '0;
            cursor_d  = 2'd3;
            state_d   = StIdle;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            dig_q     <= '0;
            cursor_q  <= 2'd3;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dig_q     <= dig_d;
            cursor_q  <= cursor_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign pin       = dig_q;
    assign pin_valid = valid_q;
    assign cursor    = cursor_q;
    assign editing   = (state_q == StEdit);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb_pin_entry_ctrl: directed and random stimulus for pin_entry_ctrl, with every output
// compared each cycle against a behavioural model of the entry rules.
module tb_pin_entry_ctrl;

    localparam int DB = 4;
    localparam int TO = 50;
    localparam int M_IDLE = 0;
    localparam int M_EDIT = 1;
    localparam int M_DONE = 2;

    logic        clk;
    logic        clr_n;
    logic        btn_up, btn_next, btn_enter, btn_clear;
    logic [15:0] pin;
    logic        pin_valid;
    logic [1:0]  cursor;
    logic        editing;
    logic        timeout;

    pin_entry_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .btn_up   (btn_up),
        .btn_next (btn_next),
        .btn_enter(btn_enter),
        .btn_clear(btn_clear),
        .pin      (pin),
        .pin_valid(pin_valid),
        .cursor   (cursor),
        .editing  (editing),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int v_cnt  = 0;
    int t_cnt  = 0;

    // Model state: accepted button levels, run lengths of disagreement, presses
    // waiting to act on the next edge, digits, cursor, mode, idle time.
    logic [3:0] m_lvl;
    logic [3:0] m_pend;
    int         m_run [4];
    int         m_dig [4];
    int         m_cur;
    int         m_mode;
    int         m_idle;
    bit         m_valid;
    bit         m_tout;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic wipe();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_cur = 3;
    endtask

    task automatic bump();
        m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
    endtask

    task automatic model_reset();
        m_lvl = '0;
        m_pend = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        wipe();
        m_mode = M_IDLE;
        m_idle = 0;
        m_valid = 0;
        m_tout = 0;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        int b;
        int prev;
`ifdef PIN_ENTRY_TIMEOUT_EN
        bit any;
        any = (m_pend != 4'b0);
`endif
        raw = {btn_clear, btn_enter, btn_next, btn_up};
        m_valid = 0;
        m_tout = 0;
        b = -1;
        // Highest-indexed pending press wins (clear, enter, next, up).
        for (int i = 0; i < 4; i++) if (m_pend[i]) b = i;
        prev = m_mode;
        if (prev == M_IDLE) begin
            if (b == 0) begin bump(); m_mode = M_EDIT; end
            else if (b == 1) begin m_cur = (m_cur + 3) % 4; m_mode = M_EDIT; end
        end else if (prev == M_EDIT) begin
            case (b)
                0: bump();
                1: m_cur = (m_cur + 3) % 4;
                2: begin m_mode = M_DONE; m_valid = 1; end
                3: begin wipe(); m_mode = M_IDLE; end
                default: ;
            endcase
        end else begin
            case (b)
                0, 1: begin wipe(); m_mode = M_EDIT; end
                2: m_valid = 1;
                3: begin wipe(); m_mode = M_IDLE; end
                default: ;
            endcase
        end
`ifdef PIN_ENTRY_TIMEOUT_EN
        if (any) m_idle = 0;
        else if (prev == M_EDIT) begin
            m_idle++;
            if (m_idle == TO) begin
                wipe();
                m_mode = M_IDLE;
                m_tout = 1;
                m_idle = 0;
            end
        end else m_idle = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            if (raw[i] == m_lvl[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i] = raw[i];
                    m_run[i] = 0;
                    m_pend[i] = raw[i];
                end
            end
        end
    endtask

    function automatic logic [15:0] m_pin();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[i*4 +: 4] = 4'(m_dig[i]);
        return p;
    endfunction

    task automatic chk_model();
        chk("pin", pin, m_pin());
        chk("pin_valid", 16'(pin_valid), 16'(m_valid));
        chk("cursor", 16'(cursor), 16'(m_cur));
        chk("editing", 16'(editing), 16'(m_mode == M_EDIT));
        chk("timeout", 16'(timeout), 16'(m_tout));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pin"}, pin, 16'h0000);
        chk({tag, "_valid"}, 16'(pin_valid), 16'h0);
        chk({tag, "_cursor"}, 16'(cursor), 16'h3);
        chk({tag, "_editing"}, 16'(editing), 16'h0);
        chk({tag, "_timeout"}, 16'(timeout), 16'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!clr_n) model_reset();
        else model_step();
        #1;
        if (pin_valid === 1'b1) v_cnt++;
        if (timeout === 1'b1) t_cnt++;
        chk_model();
    endtask

    task automatic set_btns(input logic [3:0] m);
        btn_up    = m[0];
        btn_next  = m[1];
        btn_enter = m[2];
        btn_clear = m[3];
    endtask

    task automatic press(input logic [3:0] m);
        set_btns(m);
        repeat (6) tick();
        set_btns(4'b0000);
        repeat (6) tick();
    endtask

    task automatic async_reset();
        #1;
        clr_n = 1'b0;
        #1;
        model_reset();
        chk_reset_vals("async_rst");
        tick();
        clr_n = 1'b1;
    endtask

    initial begin
        int exp_cur [5];
        logic [3:0] m;
        int hold;
        int gap;

        clr_n = 1'b0;
        set_btns(4'b0000);
        model_reset();
        tick();
        tick();
        chk_reset_vals("reset");
        clr_n = 1'b1;
        tick();

        // Bounce rejection.
        for (int c = 0; c < 20; c++) begin
            btn_up = ((c / 2) % 2 == 0);
            tick();
        end
        btn_up = 1'b1;
        repeat (8) tick();
        btn_up = 1'b0;
        repeat (8) tick();
        chk("bounce_pin", pin, 16'h1000);

        // Digit wrap and cursor wrap.
        press(4'b1000);
        repeat (10) press(4'b0001);
        chk("wrap_pin", pin, 16'h0000);
        chk("wrap_editing", 16'(editing), 16'h1);
        exp_cur = '{2, 1, 0, 3, 2};
        for (int i = 0; i < 5; i++) begin
            press(4'b0010);
            chk($sformatf("cursor_step%0d", i), 16'(cursor), 16'(exp_cur[i]));
        end

        // Full entry 4,2,0,7.
        press(4'b1000);
        repeat (4) press(4'b0001);
        press(4'b0010);
        repeat (2) press(4'b0001);
        press(4'b0010);
        press(4'b0010);
        repeat (7) press(4'b0001);
        v_cnt = 0;
        press(4'b0100);
        chk("entry_pin", pin, 16'h4207);
        chk("entry_valid_cycles", 16'(v_cnt), 16'h1);
        repeat (100) tick();
        chk("entry_pin_held", pin, 16'h4207);
        chk("entry_no_extra_valid", 16'(v_cnt), 16'h1);

        // Up and enter together while editing.
        press(4'b0001);
        chk("done_reopen_pin", pin, 16'h0000);
        press(4'b0001);
        v_cnt = 0;
        press(4'b0101);
        chk("simul_pin", pin, 16'h1000);
        chk("simul_valid_cycles", 16'(v_cnt), 16'h1);
        chk("simul_editing", 16'(editing), 16'h0);

        // Inactivity timeout.
        press(4'b1000);
        t_cnt = 0;
        press(4'b0001);
        repeat (60) tick();
`ifdef PIN_ENTRY_TIMEOUT_EN
        chk("timeout_pulses", 16'(t_cnt), 16'h1);
        chk("timeout_pin", pin, 16'h0000);
        chk("timeout_editing", 16'(editing), 16'h0);
`else
        chk("timeout_pulses", 16'(t_cnt), 16'h0);
        chk("timeout_editing", 16'(editing), 16'h1);
        chk("timeout_pin", pin, 16'h1000);
`endif

        // Asynchronous reset in the middle of an entry.
        press(4'b1000);
        repeat (3) press(4'b0001);
        press(4'b0010);
        repeat (3) press(4'b0001);
        chk("pre_reset_pin", pin, 16'h3300);
        chk("pre_reset_editing", 16'(editing), 16'h1);
        async_reset();
        tick();

        // Random stimulus with bounce and occasional resets.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: m = 4'b0001;
                4, 5, 6:    m = 4'b0010;
                7:          m = 4'b0100;
                8:          m = 4'b1000;
                default:    m = 4'($urandom_range(0, 15));
            endcase
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 7) == 0) set_btns(m ^ 4'($urandom_range(0, 15)));
                else set_btns(m);
                tick();
            end
            set_btns(4'b0000);
            gap = ($urandom_range(0, 15) == 0) ? 60 : $urandom_range(1, 12);
            repeat (gap) tick();
            if ($urandom_range(0, 63) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
